// File: rtl/fir_out_decimator_if.sv
// Handshake bundle between the FIR decimator and its producer/consumer.
// master: the decimator side; slave: the filter/consumer side.
interface fir_out_decimator_if #(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned FillW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [31:0]      data_in;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [FillW-1:0] fill_level;
  logic             overflow;

  modport master (
    input  in_valid, data_in, out_ready,
    output out_data, out_valid, fill_level, overflow
  );

  modport slave (
    output in_valid, data_in, out_ready,
    input  out_data, out_valid, fill_level, overflow
  );
endinterface

// File: rtl/fir_out_decimator.sv
// Decimates the FIR accumulator output, rounds/shifts/narrows it and buffers it in a FWFT FIFO.
// Define DEC_SAT_EN to clamp the narrowed result instead of wrapping it.
module fir_out_decimator #(
  parameter int unsigned DECIM = 4,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  fir_out_decimator_if.master bus_io
);
  localparam int unsigned PhW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic signed [32:0] RndC = 33'sd1 <<< (SHIFT - 1);

  logic [PhW-1:0]   phase_q, phase_d;
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_data_q, s1_data_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [AW:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             overflow_q, overflow_d;

  logic signed [32:0] sum, r;
  logic [OUT_W-1:0]   narrowed;
  logic               keep, empty, full, pop, push_ok;

  // Rounding add then floor shift gives round-half-up.
  always_comb begin
    sum = $signed({bus_io.data_in[31], bus_io.data_in}) + RndC;
    r   = sum >>> SHIFT;
  end

`ifdef DEC_SAT_EN
  localparam logic signed [32:0] MaxV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MinV = -(33'sd1 <<< (OUT_W - 1));

  always_comb begin
    if (r > MaxV) begin
      narrowed = MaxV[OUT_W-1:0];
    end else if (r < MinV) begin
      narrowed = MinV[OUT_W-1:0];
    end else begin
      narrowed = r[OUT_W-1:0];
    end
  end
`else
  logic unused_r_hi;
  assign unused_r_hi = ^r[32:OUT_W];
  assign narrowed    = r[OUT_W-1:0];
`endif

  always_comb begin
    keep       = bus_io.in_valid && (phase_q == '0);
    phase_d    = phase_q;
    if (bus_io.in_valid) begin
      phase_d = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + PhW'(1);
    end
    s1_valid_d = keep;
    s1_data_d  = keep ? narrowed : s1_data_q;
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty      = (rd_ptr_q == wr_ptr_q);
    full       = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    pop        = !empty && bus_io.out_ready;
    push_ok    = s1_valid_q && (!full || pop);
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
    overflow_d = overflow_q || (s1_valid_q && !push_ok);
    mem_d      = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = s1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign bus_io.out_valid  = !empty;
  assign bus_io.out_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus_io.fill_level = wr_ptr_q - rd_ptr_q;
  assign bus_io.overflow   = overflow_q;
endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench: dut_a uses DECIM=4, dut_b uses DECIM=1 for the back-pressure cases.
module tb_fir_out_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fir_out_decimator_if #(.OUT_W(16), .DEPTH(8)) ifa ();
  fir_out_decimator_if #(.OUT_W(16), .DEPTH(8)) ifb ();

  fir_out_decimator #(.DECIM(4), .SHIFT(15), .OUT_W(16), .DEPTH(8)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifa)
  );

  fir_out_decimator #(.DECIM(1), .SHIFT(15), .OUT_W(16), .DEPTH(8)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifb)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rin [6];
    int          rexp [6];
    int          q [$];
    int          first;
    int          bp_exp [8];

    ifa.in_valid = 1'b0; ifa.data_in = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.data_in = '0; ifb.out_ready = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_out_valid", int'(ifa.out_valid), 0);
    check_eq("rst_out_data", int'($signed(ifa.out_data)), 0);
    check_eq("rst_fill", int'(ifa.fill_level), 0);
    check_eq("rst_overflow", int'(ifa.overflow), 0);

    // Decimation by 4: inputs n*32768 -> retained 0 and 4
    ifa.out_ready = 1'b1;
    first = -1;
    for (int n = 0; n < 8; n++) begin
      ifa.in_valid = 1'b1;
      ifa.data_in  = 32'(n * 32768);
      step();
      if (ifa.out_valid && first < 0) first = n;
      if (ifa.out_valid) q.push_back(int'($signed(ifa.out_data)));
    end
    ifa.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ifa.out_valid) q.push_back(int'($signed(ifa.out_data)));
    end
    check_eq("dec_first_valid_step", first, 1);
    check_eq("dec_count", q.size(), 2);
    if (q.size() == 2) begin
      check_eq("dec_s0", q[0], 0);
      check_eq("dec_s1", q[1], 4);
    end

    // Rounding and narrowing, each as the first input after reset
    rin[0] = 32'd98304;       rexp[0] = 3;
    rin[1] = -32'sd16384;     rexp[1] = 0;
    rin[2] = -32'sd16385;     rexp[2] = -1;
    rin[3] = 32'd16384;       rexp[3] = 1;
    rin[4] = 32'h7FFF_FFFF;
    rin[5] = 32'h8000_0000;
`ifdef DEC_SAT_EN
    rexp[4] = 32767;  rexp[5] = -32768;
`else
    rexp[4] = 0;      rexp[5] = 0;
`endif
    for (int i = 0; i < 6; i++) begin
      ifa.out_ready = 1'b0;
      do_reset();
      ifa.in_valid = 1'b1;
      ifa.data_in  = rin[i];
      step();
      ifa.in_valid = 1'b0;
      step();
      check_eq($sformatf("rnd%0d_valid", i), int'(ifa.out_valid), 1);
      check_eq($sformatf("rnd%0d_data", i), int'($signed(ifa.out_data)), rexp[i]);
    end

    // Back-pressure on DECIM=1: 10 inputs, first 8 kept, 9 and 10 dropped
    ifb.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ifb.in_valid = 1'b1;
      ifb.data_in  = 32'((i + 1) * 32768);
      step();
    end
    ifb.data_in = 32'(11 * 32768);
    step();
    check_eq("bp_fill", int'(ifb.fill_level), 8);
    check_eq("bp_overflow", int'(ifb.overflow), 1);
    check_eq("bp_head_held", int'($signed(ifb.out_data)), 1);

    // Full FIFO, sample 11 in S1, simultaneous pop: push accepted
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    step();
    check_eq("pp_fill", int'(ifb.fill_level), 8);
    check_eq("pp_overflow", int'(ifb.overflow), 1);
    check_eq("pp_head", int'($signed(ifb.out_data)), 2);

    bp_exp = '{2, 3, 4, 5, 6, 7, 8, 11};
    q.delete();
    for (int k = 0; k < 12; k++) begin
      if (ifb.out_valid) q.push_back(int'($signed(ifb.out_data)));
      step();
    end
    check_eq("drain_count", q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < q.size()) check_eq($sformatf("drain%0d", k), q[k], bp_exp[k]);
    end
    check_eq("drain_valid_low", int'(ifb.out_valid), 0);
    check_eq("drain_fill", int'(ifb.fill_level), 0);

    // Mid-stream reset with 5 words buffered
    ifa.out_ready = 1'b0;
    do_reset();
    for (int n = 0; n < 17; n++) begin
      ifa.in_valid = 1'b1;
      ifa.data_in  = 32'((n + 1) * 32768);
      step();
    end
    ifa.in_valid = 1'b0;
    step();
    step();
    check_eq("mid_fill_before", int'(ifa.fill_level), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_valid", int'(ifa.out_valid), 0);
    check_eq("mid_fill", int'(ifa.fill_level), 0);
    check_eq("mid_overflow", int'(ifa.overflow), 0);
    ifa.in_valid = 1'b1;
    ifa.data_in  = 32'(5 * 32768);
    step();
    ifa.in_valid = 1'b0;
    step();
    check_eq("post_rst_valid", int'(ifa.out_valid), 1);
    check_eq("post_rst_data", int'($signed(ifa.out_data)), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Downstream stage of the 128-tap FIR filter. It consumes the filter's signed 32-bit accumulator output and decimates it by a fixed ratio. Each retained sample is rounded, shifted and saturated to a narrow signed word, then buffered in a small FIFO. The FIFO presents samples to the next consumer over a valid/ready handshake, so back-pressure never stalls the free-running filter.

## Interface
- DECIM, 4: decimation ratio; keep 1 of every DECIM valid inputs (DECIM ≥ 1).
- SHIFT, 15: arithmetic right-shift applied after rounding (1 ≤ SHIFT ≤ 30).
- OUT_W, 16: output word width, signed.
- DEPTH, 8: FIFO depth in words; power of 2, ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in carries a new filter sample this cycle.
- data_in  input  32  signed filter output (the FIR's data_out).
- out_data  output  OUT_W  signed decimated sample at FIFO head.
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  consumer accepts out_data this cycle.
- fill_level  output  $clog2(DEPTH)+1  number of words currently stored in the FIFO.
- overflow  output  1  sticky flag, set when a sample is dropped because the FIFO was full.

## Operation
- Phase counter `phase` runs 0..DECIM-1.
  - Advances only on `in_valid`.
  - Wraps from DECIM-1 to 0.
- A sample is retained when `in_valid && phase == 0`. Other valid samples are discarded. With DECIM=1, every valid sample is retained.
- Round/shift is computed in 33 bits:
  - `r = (sext33(data_in) + 2^(SHIFT-1)) >>> SHIFT`.
  - This is round-half-up toward +inf, because `>>>` floors.
- Narrowing is controlled by `DEC_SAT_EN` (see Configuration):
  - Saturation clamps `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Otherwise `r` is truncated to its low OUT_W bits.
- Pipeline: the retained sample is registered in stage register S1 (with a valid bit), then written to the FIFO on the next edge.
- FIFO behaviour:
  - Circular buffer with rd/wr pointers one bit wider than the address, for the full/empty distinction.
  - First-word-fall-through: out_data is driven from the head entry.
  - `out_valid` = not empty.
- Pop occurs when `out_valid && out_ready`.
- Push occurs when S1 is valid. Push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
- A push that does not succeed drops the sample:
  - Set `overflow`; it stays set until `rst`.
  - Pointers are unchanged.
- Simultaneous push and pop:
  - When empty: only the push takes effect, since out_valid was 0 and no pop is possible.
  - Otherwise: both take effect and `fill_level` is unchanged.
- `out_ready` while `out_valid=0` is ignored.

## Timing
- Reset values:
  - out_valid=0, out_data=0, fill_level=0, overflow=0.
  - phase=0, S1 valid=0, pointers=0.
- Reset mid-operation flushes FIFO and S1 contents on that edge. The next retained sample is the first valid input after rst deasserts (phase=0).
- Latency, with the retained sample presented at edge k into an empty FIFO:
  - S1 loads at edge k.
  - FIFO write at edge k+1.
  - out_valid=1 and out_data valid in the cycle after edge k+1.
- Throughput: one push and one pop per cycle, sustained.
- fill_level and overflow update on the same edge as the push/pop that changes them.
- out_data remains stable while out_valid=1 and out_ready=0.

## Configuration
- `DEC_SAT_EN` defined: saturation is compiled in; the result is clamped to the OUT_W signed range.
- `DEC_SAT_EN` undefined: the saturation comparators are removed; the result wraps (low OUT_W bits of `r`).
- Rounding, decimation and the FIFO are identical in both builds.

## Test plan
All cases use DECIM=4, SHIFT=15, OUT_W=16, DEPTH=8 unless stated.
- Decimation: in_valid=1 for 8 cycles with data_in = n·32768 (n=0..7), out_ready=1 → out_data sequence 0, 4; out_valid first high the cycle after the second edge following the n=0 input.
- Rounding, each as the first input after reset:
  - data_in=98304 → 3.
  - data_in=-16384 → 0.
  - data_in=-16385 → -1.
  - data_in=16384 → 1.
- Saturation:
  - data_in=32'h7FFF_FFFF → 32767 with `DEC_SAT_EN`; 0 without.
  - data_in=32'h8000_0000 → -32768 with `DEC_SAT_EN`; 0 without.
- Back-pressure:
  - out_ready=0, DECIM=1, 10 consecutive valid inputs → fill_level=8, overflow=1, and the FIFO holds the first 8 samples in order.
  - Then out_ready=1 → the 8 samples drain in order and out_valid falls after the 8th pop.
- Full with simultaneous push and pop: FIFO at 8 words, out_ready=1 and a new sample in S1 → push accepted, fill_level stays 8, overflow unchanged.
- Reset mid-stream: rst asserted for 1 cycle with 5 words buffered → next cycle out_valid=0, fill_level=0, overflow=0; the first post-reset valid input is retained.
